// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Requester handshakes and register-file write port bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  s0_valid;
  logic                  s0_ready;
  logic [ADDR_WIDTH-1:0] s0_addr;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s1_valid;
  logic                  s1_ready;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  stall;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  busy;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output stall,
    input  s0_ready, s1_ready,
    input  RegWrite, write_address, write_data, busy
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  stall,
    output s0_ready, s1_ready,
    output RegWrite, write_address, write_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Two-source FIFO-buffered arbiter for the register file write
//               port. WB_ROUND_ROBIN_EN selects round-robin, else source 1 wins.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);
  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam int                 c_ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

  logic [1:0]            w_in_valid;
  logic [1:0]            w_ready;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            w_nonempty;
  logic [c_ENTRY_W-1:0]  w_in_entry [2];
  logic [c_ENTRY_W-1:0]  w_head     [2];
  logic                  w_issue;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_write_address;
  logic [DATA_WIDTH-1:0] r_write_data;

  assign w_in_valid    = {bus.s1_valid, bus.s0_valid};
  assign w_in_entry[0] = {bus.s0_addr, bus.s0_data};
  assign w_in_entry[1] = {bus.s1_addr, bus.s1_data};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;

    // Ready ignores same-edge pop credit, so a full FIFO never accepts.
    assign w_ready[gi]    = !rst && (r_count != c_FULL);
    assign w_push[gi]     = w_in_valid[gi] && w_ready[gi];
    assign w_nonempty[gi] = (r_count != '0);
    assign w_head[gi]     = r_mem[r_rptr];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[gi]) begin
          r_mem[r_wptr] <= w_in_entry[gi];
          r_wptr        <= r_wptr + c_PTR_W'(1);
        end
        if (w_pop[gi]) begin
          r_rptr <= r_rptr + c_PTR_W'(1);
        end
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_issue) begin
      r_last <= w_grant;
    end
  end

  always_comb begin
    w_grant = w_nonempty[1];
    if (&w_nonempty) begin
      w_grant = ~r_last;
    end
  end
`else
  // Load writeback has fixed priority over ALU writeback.
  always_comb begin
    w_grant = w_nonempty[1];
  end
`endif

  assign w_issue                  = !bus.stall && (|w_nonempty);
  assign w_pop                    = w_issue ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign {w_sel_addr, w_sel_data} = w_head[w_grant];

  // Address/data hold when idle; only the enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write     <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
    end else if (w_issue) begin
      r_reg_write     <= (w_sel_addr != '0);
      r_write_address <= w_sel_addr;
      r_write_data    <= w_sel_data;
    end else begin
      r_reg_write     <= 1'b0;
    end
  end

  assign bus.s0_ready      = w_ready[0];
  assign bus.s1_ready      = w_ready[1];
  assign bus.RegWrite      = r_reg_write;
  assign bus.write_address = r_write_address;
  assign bus.write_data    = r_write_data;
  assign bus.busy          = (|w_nonempty) || r_reg_write;
endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed and randomized bench against a queue-based model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc_cnt = 0;

  wr_t           q0[$];
  wr_t           q1[$];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
`ifdef WB_ROUND_ROBIN_EN
  logic          m_last;
`endif
  logic [AW-1:0] issue_log[$];
  int            issue_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic st,
                     input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic rdy0, rdy1, ne0, ne1, g;
    wr_t  e;
    rst          = r;
    bus.stall    = st;
    bus.s0_valid = v0; bus.s0_addr = a0; bus.s0_data = d0;
    bus.s1_valid = v1; bus.s1_addr = a1; bus.s1_data = d1;
    #1;
    rdy0 = !r && (q0.size() != DEPTH);
    rdy1 = !r && (q1.size() != DEPTH);
    check_eq("s0_ready", bus.s0_ready, rdy0);
    check_eq("s1_ready", bus.s1_ready, rdy1);
    @(posedge clk);
    cyc_cnt++;
    if (r) begin
      q0.delete(); q1.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0;
`ifdef WB_ROUND_ROBIN_EN
      m_last = 1'b1;
`endif
    end else begin
      ne0 = (q0.size() > 0);
      ne1 = (q1.size() > 0);
      if (!st && (ne0 || ne1)) begin
        g = ne1;
`ifdef WB_ROUND_ROBIN_EN
        if (ne0 && ne1) g = !m_last;
        m_last = g;
`endif
        e      = g ? q1.pop_front() : q0.pop_front();
        m_we   = (e.a != '0);
        m_addr = e.a;
        m_data = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (v0 && rdy0) q0.push_back({a0, d0});
      if (v1 && rdy1) q1.push_back({a1, d1});
    end
    #1;
    check_eq("RegWrite", bus.RegWrite, m_we);
    check_eq("write_address", bus.write_address, m_addr);
    check_eq("write_data", bus.write_data, m_data);
    check_eq("busy", bus.busy, (q0.size() > 0) || (q1.size() > 0) || m_we);
    if (bus.RegWrite === 1'b1) begin
      issue_log.push_back(bus.write_address);
      issue_cyc.push_back(cyc_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic clear_log();
    issue_log.delete();
    issue_cyc.delete();
  endtask

  initial begin
    logic [AW-1:0] exp_order [4];
    logic [AW-1:0] stall_order [3];
`ifdef WB_ROUND_ROBIN_EN
    exp_order = '{5'd1, 5'd3, 5'd2, 5'd4};
`else
    exp_order = '{5'd3, 5'd4, 5'd1, 5'd2};
`endif
    stall_order = '{5'd7, 5'd8, 5'd9};

    // Reset release
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(1);

    // Single write
    cyc(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    clear_log();
    idle(3);
    check_eq("single_count", issue_log.size(), 1);
    if (issue_log.size() == 1) begin
      check_eq("single_addr", issue_log[0], 5);
      check_eq("single_latency", issue_cyc[0], cyc_cnt - 2);
    end

    // Contention from a fresh arbitration state
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    clear_log();
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    cyc(1'b0, 1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    idle(5);
    check_eq("order_count", issue_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < issue_log.size()) check_eq("order_addr", issue_log[i], exp_order[i]);
    end

    // r0 discard
    clear_log();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFF);
    check_eq("r0_busy_pending", bus.busy, 1'b1);
    idle(2);
    check_eq("r0_no_write", issue_log.size(), 0);
    check_eq("r0_busy_cleared", bus.busy, 1'b0);

    // Full FIFO under stall, then release
    clear_log();
    cyc(1'b0, 1'b1, 1'b1, 5'd7, 32'hA1, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 1'b1, 5'd8, 32'hA2, 1'b0, '0, '0);
    check_eq("full_ready_low", bus.s0_ready, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 5'd9, 32'hA3, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 5'd9, 32'hA3, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 5'd9, 32'hA3, 1'b0, '0, '0);
    idle(3);
    check_eq("stall_count", issue_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < issue_log.size()) check_eq("stall_order", issue_log[i], stall_order[i]);
      if (i > 0 && i < issue_cyc.size()) check_eq("stall_back_to_back", issue_cyc[i] - issue_cyc[i-1], 1);
    end

    // Reset mid-operation
    cyc(1'b0, 1'b1, 1'b1, 5'd10, 32'hB0, 1'b1, 5'd11, 32'hB1);
    cyc(1'b0, 1'b1, 1'b1, 5'd12, 32'hB2, 1'b1, 5'd13, 32'hB3);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    clear_log();
    idle(3);
    check_eq("midrst_no_write", issue_log.size(), 0);
    check_eq("midrst_busy", bus.busy, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom),
          $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

`default_nettype wire
